// File: rtl/jtag_tap_core.sv
// jtag_tap_core
//   IEEE 1149.1 TAP core. It holds the 16-state TAP controller, the
//   instruction register and its decoder, the IDCODE and BYPASS data
//   registers, and NUM_UDR user data registers. Each user data register has
//   a parallel capture input, an update shadow output and an update strobe.
//   The core runs only on TCK.
//
// Ports
//   TCK               test clock, the only clock
//   TRST              asynchronous active-low reset
//   TMS, TDI          sampled on the TCK rising edge
//   TDO, tdo_en       registered on the TCK falling edge
//   tap_state         current TAP state encoding
//   tap_reset         high while in Test-Logic-Reset
//   ir_value          active instruction
//   udr_capture_in    parallel capture data, slice k belongs to UDRk
//   udr_update_out    update shadow registers, slice k belongs to UDRk
//   udr_update_strobe one-cycle pulse per UDR after Update-DR
module jtag_tap_core #(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1A2B3C4D,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP    = IR_WIDTH'(1),
  parameter int                  NUM_UDR      = 2,
  parameter int                  UDR_WIDTH    = 32,
  parameter logic [IR_WIDTH-1:0] UDR_BASE     = IR_WIDTH'(8)
) (
  input  logic                           TCK,
  input  logic                           TRST,
  input  logic                           TMS,
  input  logic                           TDI,
  output logic                           TDO,
  output logic                           tdo_en,
  output logic [3:0]                     tap_state,
  output logic                           tap_reset,
  output logic [IR_WIDTH-1:0]            ir_value,
  input  logic [NUM_UDR*UDR_WIDTH-1:0]   udr_capture_in,
  output logic [NUM_UDR*UDR_WIDTH-1:0]   udr_update_out,
  output logic [NUM_UDR-1:0]             udr_update_strobe
);

  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_e;

  tap_state_e             state;
  tap_state_e             next_state;
  logic [IR_WIDTH-1:0]    ir_sr;
  logic [31:0]            idcode_sr;
  logic                   bypass_sr;
  logic [UDR_WIDTH-1:0]   udr_sr;
  logic [UDR_WIDTH-1:0]   udr_cap_data;
  logic [IR_WIDTH-1:0]    udr_offset;
  logic                   sel_idcode;
  logic                   sel_udr;
  logic [NUM_UDR-1:0]     udr_hit;
  logic                   dr_lsb;

  assign tap_state = state;
  assign tap_reset = (state == TLR);

  // TAP state register
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state <= TLR;
    end else begin
      state <= next_state;
    end
  end

  // TAP next-state logic, driven by TMS only
  always_comb begin
    next_state = state;
    case (state)
      TLR:      next_state = TMS ? TLR      : RTI;
      RTI:      next_state = TMS ? SEL_DR   : RTI;
      SEL_DR:   next_state = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = TMS ? EX1_DR   : SH_DR;
      SH_DR:    next_state = TMS ? EX1_DR   : SH_DR;
      EX1_DR:   next_state = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = TMS ? EX2_DR   : PAUSE_DR;
      EX2_DR:   next_state = TMS ? UPD_DR   : SH_DR;
      UPD_DR:   next_state = TMS ? SEL_DR   : RTI;
      SEL_IR:   next_state = TMS ? TLR      : CAP_IR;
      CAP_IR:   next_state = TMS ? EX1_IR   : SH_IR;
      SH_IR:    next_state = TMS ? EX1_IR   : SH_IR;
      EX1_IR:   next_state = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = TMS ? EX2_IR   : PAUSE_IR;
      EX2_IR:   next_state = TMS ? UPD_IR   : SH_IR;
      UPD_IR:   next_state = TMS ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  end

  // IDCODE wins if its opcode ever overlaps the UDR range; anything that is
  // neither IDCODE nor a UDR opcode falls through to BYPASS.
  assign udr_offset = ir_value - UDR_BASE;
  assign sel_idcode = (ir_value == IDCODE_OP);
  assign sel_udr    = !sel_idcode && (ir_value >= UDR_BASE) &&
                      (udr_offset < IR_WIDTH'(NUM_UDR));

  always_comb begin
    udr_hit = '0;
    for (int k = 0; k < NUM_UDR; k++) begin
      udr_hit[k] = sel_udr && (udr_offset == IR_WIDTH'(k));
    end
  end

  always_comb begin
    udr_cap_data = '0;
    for (int k = 0; k < NUM_UDR; k++) begin
      if (udr_hit[k]) begin
        udr_cap_data = udr_capture_in[k*UDR_WIDTH +: UDR_WIDTH];
      end
    end
  end

  // Instruction path. ir_value is reloaded with IDCODE on the edge that
  // enters Test-Logic-Reset, so it is valid as soon as tap_reset rises.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sr    <= '0;
      ir_value <= IDCODE_OP;
    end else begin
      if (state == CAP_IR) begin
        ir_sr <= IR_WIDTH'(1);
      end else if (state == SH_IR) begin
        ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
      end
      if (next_state == TLR) begin
        ir_value <= IDCODE_OP;
      end else if (state == UPD_IR) begin
        ir_value <= ir_sr;
      end
    end
  end

  // Data registers. All UDRs share one shift register because only one
  // can be selected during a scan, and every scan passes Capture-DR first.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      idcode_sr <= '0;
      bypass_sr <= 1'b0;
      udr_sr    <= '0;
    end else if (state == CAP_DR) begin
      if (sel_idcode) begin
        idcode_sr <= IDCODE_VALUE;
      end else if (sel_udr) begin
        udr_sr <= udr_cap_data;
      end else begin
        bypass_sr <= 1'b0;
      end
    end else if (state == SH_DR) begin
      if (sel_idcode) begin
        idcode_sr <= {TDI, idcode_sr[31:1]};
      end else if (sel_udr) begin
        udr_sr <= {TDI, udr_sr[UDR_WIDTH-1:1]};
      end else begin
        bypass_sr <= TDI;
      end
    end
  end

  // UDR update happens on the edge leaving Update-DR; the strobe is raised
  // by the same edge so it covers exactly the following TCK cycle.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      udr_update_out    <= '0;
      udr_update_strobe <= '0;
    end else begin
      udr_update_strobe <= '0;
      if (state == UPD_DR) begin
        for (int k = 0; k < NUM_UDR; k++) begin
          if (udr_hit[k]) begin
            udr_update_out[k*UDR_WIDTH +: UDR_WIDTH] <= udr_sr;
            udr_update_strobe[k]                     <= 1'b1;
          end
        end
      end
    end
  end

  assign dr_lsb = sel_idcode ? idcode_sr[0] :
                  sel_udr    ? udr_sr[0]    : bypass_sr;

  // TDO changes on the falling edge so it is stable at the next rising edge
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      TDO    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      TDO    <= 1'b0;
      tdo_en <= 1'b0;
      if (state == SH_IR) begin
        TDO    <= ir_sr[0];
        tdo_en <= 1'b1;
      end else if (state == SH_DR) begin
        TDO    <= dr_lsb;
        tdo_en <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_core.sv
// tb_jtag_tap_core
//   Self-checking bench for jtag_tap_core. A behavioural model steps the
//   TAP through a transition table and keeps the shift registers as plain
//   integers. Directed scans and a table-driven state walk cover the corner
//   cases, and randomized scans cover the rest.
module tb_jtag_tap_core;

  localparam int          IRW        = 4;
  localparam logic [31:0] IDCODE_VAL = 32'h1A2B3C4D;
  localparam logic [3:0]  IDCODE_OP  = 4'h1;
  localparam int          NUDR       = 2;
  localparam int          UDRW       = 32;
  localparam logic [3:0]  UDR_BASE   = 4'h8;

  localparam int S_TLR   = 15;
  localparam int S_RTI   = 12;
  localparam int S_CAPDR = 6;
  localparam int S_SHDR  = 2;
  localparam int S_UPDDR = 5;
  localparam int S_CAPIR = 14;
  localparam int S_SHIR  = 10;
  localparam int S_UPDIR = 13;

  logic                   TCK  = 1'b0;
  logic                   TRST = 1'b1;
  logic                   TMS  = 1'b1;
  logic                   TDI  = 1'b0;
  logic                   TDO;
  logic                   tdo_en;
  logic [3:0]             tap_state;
  logic                   tap_reset;
  logic [IRW-1:0]         ir_value;
  logic [NUDR*UDRW-1:0]   udr_capture_in = '0;
  logic [NUDR*UDRW-1:0]   udr_update_out;
  logic [NUDR-1:0]        udr_update_strobe;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int                 m_state;
  logic [IRW-1:0]     m_ir;
  logic [IRW-1:0]     m_irsr;
  logic [31:0]        m_dr;
  logic [UDRW-1:0]    m_udr [NUDR];
  logic [NUDR-1:0]    m_strobe;
  logic               m_tdo;
  logic               m_tdoen;
  int                 nxt0 [16];
  int                 nxt1 [16];

  typedef struct {
    bit         tms;
    logic [3:0] exp_state;
  } walk_t;
  walk_t walk [19];

  jtag_tap_core #(
    .IR_WIDTH     (IRW),
    .IDCODE_VALUE (IDCODE_VAL),
    .IDCODE_OP    (IDCODE_OP),
    .NUM_UDR      (NUDR),
    .UDR_WIDTH    (UDRW),
    .UDR_BASE     (UDR_BASE)
  ) dut (
    .TCK               (TCK),
    .TRST              (TRST),
    .TMS               (TMS),
    .TDI               (TDI),
    .TDO               (TDO),
    .tdo_en            (tdo_en),
    .tap_state         (tap_state),
    .tap_reset         (tap_reset),
    .ir_value          (ir_value),
    .udr_capture_in    (udr_capture_in),
    .udr_update_out    (udr_update_out),
    .udr_update_strobe (udr_update_strobe)
  );

  always #5 TCK = ~TCK;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic int udr_index(input logic [3:0] ir);
    int off;
    off = int'(ir) - int'(UDR_BASE);
    if (ir != IDCODE_OP && off >= 0 && off < NUDR) return off;
    return -1;
  endfunction

  function automatic int dr_len(input logic [3:0] ir);
    if (ir == IDCODE_OP) return 32;
    if (udr_index(ir) >= 0) return UDRW;
    return 1;
  endfunction

  function automatic logic [NUDR*UDRW-1:0] model_udr_out();
    logic [NUDR*UDRW-1:0] v;
    v = '0;
    for (int k = 0; k < NUDR; k++) v[k*UDRW +: UDRW] = m_udr[k];
    return v;
  endfunction

  task automatic model_reset();
    m_state  = S_TLR;
    m_ir     = IDCODE_OP;
    m_irsr   = '0;
    m_dr     = '0;
    m_strobe = '0;
    m_tdo    = 1'b0;
    m_tdoen  = 1'b0;
    for (int k = 0; k < NUDR; k++) m_udr[k] = '0;
  endtask

  task automatic model_posedge(input bit tms, input bit tdi);
    int k;
    int len;
    k   = udr_index(m_ir);
    len = dr_len(m_ir);
    m_strobe = '0;
    case (m_state)
      S_CAPIR: m_irsr = IRW'(1);
      S_SHIR:  m_irsr = (m_irsr >> 1) | (IRW'(tdi) << (IRW - 1));
      S_UPDIR: m_ir = m_irsr;
      S_CAPDR: begin
        if (m_ir == IDCODE_OP) m_dr = IDCODE_VAL;
        else if (k >= 0)       m_dr = udr_capture_in[k*UDRW +: UDRW];
        else                   m_dr = 32'd0;
      end
      S_SHDR: begin
        m_dr = m_dr >> 1;
        m_dr[len-1] = tdi;
      end
      S_UPDDR: begin
        if (k >= 0) begin
          m_udr[k]    = m_dr;
          m_strobe[k] = 1'b1;
        end
      end
      default: ;
    endcase
    m_state = tms ? nxt1[m_state] : nxt0[m_state];
    if (m_state == S_TLR) m_ir = IDCODE_OP;
  endtask

  task automatic model_negedge();
    m_tdoen = (m_state == S_SHIR) || (m_state == S_SHDR);
    if (m_state == S_SHIR)      m_tdo = m_irsr[0];
    else if (m_state == S_SHDR) m_tdo = m_dr[0];
    else                        m_tdo = 1'b0;
  endtask

  // One full TCK cycle: drive inputs, check after each edge against the model
  task automatic applyStimulus(input bit tms, input bit tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    model_posedge(tms, tdi);
    #1;
    checkOutput("tap_state", 64'(tap_state), 64'(m_state));
    checkOutput("tap_reset", 64'(tap_reset), 64'(m_state == S_TLR));
    checkOutput("ir_value", 64'(ir_value), 64'(m_ir));
    checkOutput("udr_update_out", 64'(udr_update_out), 64'(model_udr_out()));
    checkOutput("udr_update_strobe", 64'(udr_update_strobe), 64'(m_strobe));
    @(negedge TCK);
    model_negedge();
    #1;
    checkOutput("TDO", 64'(TDO), 64'(m_tdo));
    checkOutput("tdo_en", 64'(tdo_en), 64'(m_tdoen));
  endtask

  task automatic applyReset();
    TRST = 1'b0;
    model_reset();
    #1;
    checkOutput("rst_state", 64'(tap_state), 64'hF);
    checkOutput("rst_tap_reset", 64'(tap_reset), 64'd1);
    checkOutput("rst_ir_value", 64'(ir_value), 64'h1);
    checkOutput("rst_TDO", 64'(TDO), 64'd0);
    checkOutput("rst_tdo_en", 64'(tdo_en), 64'd0);
    checkOutput("rst_udr_out", 64'(udr_update_out), 64'd0);
    checkOutput("rst_strobe", 64'(udr_update_strobe), 64'd0);
    @(negedge TCK);
    #1;
    TRST = 1'b1;
  endtask

  // From Run-Test/Idle: load an opcode, return TDO bits seen while shifting
  task automatic scan_ir(input logic [3:0] op, output logic [3:0] tdo_bits);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < IRW; i++) begin
      tdo_bits[i] = TDO;
      applyStimulus(i == IRW - 1, op[i]);
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  // From Run-Test/Idle: DR scan of len bits, optional Pause-DR detour after
  // pause_at bits (0 = none); returns TDO stream and the update strobe.
  task automatic scan_dr(input logic [31:0] data, input int len, input int pause_at,
                         output logic [31:0] tdo_bits, output logic [NUDR-1:0] strobe_seen);
    tdo_bits = '0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      tdo_bits[i] = TDO;
      if (i == pause_at - 1 && i != len - 1) begin
        applyStimulus(1'b1, data[i]);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
      end else begin
        applyStimulus(i == len - 1, data[i]);
      end
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    strobe_seen = udr_update_strobe;
    applyStimulus(1'b0, 1'b0);
    checkOutput("strobe_one_cycle", 64'(udr_update_strobe), 64'd0);
  endtask

  initial begin
    logic [3:0]       irb;
    logic [31:0]      tdo_stream;
    logic [NUDR-1:0]  sb;
    logic [3:0]       op;
    int               len;
    int               pa;
    int               nrand;

    nxt0 = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    nxt1 = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    walk[0]  = '{1'b0, 4'hC};
    walk[1]  = '{1'b1, 4'h7};
    walk[2]  = '{1'b0, 4'h6};
    walk[3]  = '{1'b0, 4'h2};
    walk[4]  = '{1'b1, 4'h1};
    walk[5]  = '{1'b0, 4'h3};
    walk[6]  = '{1'b1, 4'h0};
    walk[7]  = '{1'b1, 4'h5};
    walk[8]  = '{1'b1, 4'h7};
    walk[9]  = '{1'b1, 4'h4};
    walk[10] = '{1'b0, 4'hE};
    walk[11] = '{1'b0, 4'hA};
    walk[12] = '{1'b1, 4'h9};
    walk[13] = '{1'b0, 4'hB};
    walk[14] = '{1'b1, 4'h8};
    walk[15] = '{1'b1, 4'hD};
    walk[16] = '{1'b1, 4'h7};
    walk[17] = '{1'b1, 4'h4};
    walk[18] = '{1'b1, 4'hF};

    #1;
    applyReset();

    // IDCODE read straight out of reset
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    tdo_stream = '0;
    for (int i = 0; i < 32; i++) begin
      tdo_stream[i] = TDO;
      if (i == 0 || i == 31) checkOutput("idcode_tdo_en", 64'(tdo_en), 64'd1);
      applyStimulus(i == 31, 1'b0);
    end
    checkOutput("idcode_stream", 64'(tdo_stream), 64'h1A2B3C4D);
    checkOutput("ex1dr_tdo_en", 64'(tdo_en), 64'd0);
    checkOutput("ex1dr_TDO", 64'(TDO), 64'd0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);

    // BYPASS through all-ones and through an undecoded opcode
    scan_ir(4'hF, irb);
    checkOutput("ir_capture_F", 64'(irb), 64'b0001);
    checkOutput("ir_value_F", 64'(ir_value), 64'hF);
    scan_dr(32'b1101, 4, 0, tdo_stream, sb);
    checkOutput("bypass_F_stream", 64'(tdo_stream[3:0]), 64'b1010);
    checkOutput("bypass_F_strobe", 64'(sb), 64'd0);
    scan_ir(4'h7, irb);
    checkOutput("ir_value_7", 64'(ir_value), 64'h7);
    scan_dr(32'b1101, 4, 0, tdo_stream, sb);
    checkOutput("bypass_7_stream", 64'(tdo_stream[3:0]), 64'b1010);

    // UDR1 then UDR0 capture/update
    udr_capture_in = {32'hA5A5_5A5A, 32'h0BAD_F00D};
    scan_ir(4'h9, irb);
    scan_dr(32'h1234_5678, 32, 0, tdo_stream, sb);
    checkOutput("udr1_stream", 64'(tdo_stream), 64'hA5A5_5A5A);
    checkOutput("udr1_out", 64'(udr_update_out), 64'h1234_5678_0000_0000);
    checkOutput("udr1_strobe", 64'(sb), 64'b10);
    scan_ir(4'h8, irb);
    scan_dr(32'hDEAD_BEEF, 32, 0, tdo_stream, sb);
    checkOutput("udr0_stream", 64'(tdo_stream), 64'h0BAD_F00D);
    checkOutput("udr0_out", 64'(udr_update_out), 64'h1234_5678_DEAD_BEEF);
    checkOutput("udr0_strobe", 64'(sb), 64'b01);

    // UDR1 scan with a Pause-DR detour, then an IDCODE update does nothing
    scan_ir(4'h9, irb);
    scan_dr(32'h8765_4321, 32, 10, tdo_stream, sb);
    checkOutput("pause_stream", 64'(tdo_stream), 64'hA5A5_5A5A);
    checkOutput("pause_out", 64'(udr_update_out), 64'h8765_4321_DEAD_BEEF);
    checkOutput("pause_strobe", 64'(sb), 64'b10);
    scan_ir(4'h1, irb);
    scan_dr(32'hFFFF_0000, 32, 0, tdo_stream, sb);
    checkOutput("idcode_upd_stream", 64'(tdo_stream), 64'h1A2B3C4D);
    checkOutput("idcode_upd_strobe", 64'(sb), 64'd0);
    checkOutput("idcode_upd_out", 64'(udr_update_out), 64'h8765_4321_DEAD_BEEF);

    // From every state, five TMS=1 clocks reach Test-Logic-Reset
    for (int s = 0; s < 19; s++) begin
      for (int i = 0; i <= s; i++) begin
        applyStimulus(walk[i].tms, 1'b0);
        checkOutput("walk_state", 64'(tap_state), 64'(walk[i].exp_state));
      end
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("tlr_state", 64'(tap_state), 64'hF);
      checkOutput("tlr_ir", 64'(ir_value), 64'h1);
      checkOutput("tlr_udr_kept", 64'(udr_update_out), 64'h8765_4321_DEAD_BEEF);
    end

    // TRST in the middle of a UDR1 shift
    applyStimulus(1'b0, 1'b0);
    scan_ir(4'h9, irb);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1);
    applyReset();
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_trst_state", 64'(tap_state), 64'hC);
    checkOutput("post_trst_strobe", 64'(udr_update_strobe), 64'd0);
    checkOutput("post_trst_udr", 64'(udr_update_out), 64'd0);

    // Randomized scans and TMS walks against the model
    for (int it = 0; it < 40; it++) begin
      udr_capture_in = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       op = 4'h1;
        1:       op = 4'h8;
        2:       op = 4'h9;
        default: op = 4'($urandom);
      endcase
      scan_ir(op, irb);
      checkOutput("rand_ir_capture", 64'(irb), 64'b0001);
      len = int'($urandom_range(1, 32));
      pa  = int'($urandom_range(0, 32));
      scan_dr($urandom, len, pa, tdo_stream, sb);
      nrand = int'($urandom_range(0, 8));
      for (int j = 0; j < nrand; j++) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      for (int j = 0; j < 5; j++) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
      applyStimulus(1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
